pkt_to_msg_queue: RTL and testbench
===================================

Name: pkt_to_msg_queue

Overview:
Downstream stage of the NIC receive-side flits buffer. It accepts a complete packet (MAX_PACKET_LENGHT flits, flattened) through the request/stall handshake, then stores it in a DEPTH-entry circular packet FIFO. It decodes the packet length from the flit-type fields and presents packets in order to the message-assembly / WISHBONE side with a request/acknowledge handshake.

Parameters:
DEPTH, 4, number of packet slots in the queue (power of 2, ≥2)
N_BITS_PTR, 2, clog2(DEPTH); read and write pointer width
N_BITS_LEN, 4, width of the packet-length field; must hold the value `MAX_PACKET_LENGHT

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
r_pkt_to_msg_i  in  1  upstream request; a complete packet is present on in_link_i
in_link_i  in  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet; flit 0 at bits [`FLIT_WIDTH-1:0] is head/head_tail, flit i at bits [(i+1)*`FLIT_WIDTH-1 : i*`FLIT_WIDTH]
stall_pkt_to_msg_o  out  1  high = packet not accepted this cycle
r_msg_o  out  1  head-of-queue packet valid
out_link_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  head-of-queue packet, same layout as in_link_i
out_len_o  out  N_BITS_LEN  number of valid flits in out_link_o (1..`MAX_PACKET_LENGHT)
out_err_o  out  1  head-of-queue packet is malformed
ack_msg_i  in  1  consumer pops the head-of-queue packet (valid only while r_msg_o=1)
count_o  out  N_BITS_PTR+1  packets currently stored
malformed_o  out  1  one-cycle pulse when a malformed packet is accepted

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low. Reset clears wr_ptr, rd_ptr and count. After reset, stall_pkt_to_msg_o=0, r_msg_o=0, count_o=0, malformed_o=0, out_err_o=0, out_len_o=0. Packet storage is not reset.
- Reset while a request is pending: the packet is dropped. The request is re-sampled after reset is released.
- Stall: stall_pkt_to_msg_o = (count == DEPTH). This is purely combinational from registered state; there is no path from r_pkt_to_msg_i or ack_msg_i to the stall output. Upstream treats "request high and stall low" as accepted in that same cycle, so the queue must capture the packet at that clock edge.
- Push: when r_pkt_to_msg_i & !full, at the clock edge:
  - write the packet to mem[wr_ptr], together with the decoded length and the error flag;
  - wr_ptr = wr_ptr + 1, wrapping modulo DEPTH.
- Full: a push attempted while full is ignored (stall is high), even if ack_msg_i is asserted in the same cycle. There is no pass-through on a pop.
- Pop: when ack_msg_i & r_msg_o, rd_ptr = rd_ptr + 1, wrapping modulo DEPTH. ack_msg_i while empty is ignored.
- Count: count updates +1 on push only, −1 on pop only, and is unchanged on a simultaneous push and pop.
- Output view: first-word fall-through.
  - r_msg_o = (count != 0).
  - out_link_o, out_len_o and out_err_o = mem[rd_ptr] fields.
  - Latency from push to visibility when the queue is empty is 1 cycle.
- Length decode (combinational, on in_link_i), using flit type in_link_i flit k [`FLIT_TYPE_BITS]:
  - flit 0 is `HEAD_TAIL_FLIT → len = 1, err = 0.
  - flit 0 is `HEAD_FLIT → len = k+1 for the lowest k≥1 whose type is `TAIL_FLIT, err = 0. If no tail exists → len = `MAX_PACKET_LENGHT, err = 1.
  - flit 0 is any other type → len = `MAX_PACKET_LENGHT, err = 1.
  - Flits beyond the tail are don't-care; the storage is not cleared upstream.
- malformed_o: pulses in the cycle after a push with err = 1. Malformed packets are still queued, in order.
- Pointer wrap: pointers are N_BITS_PTR wide and wrap naturally. full/empty are distinguished by count, never by pointer equality alone.

Decomposition:
- Shared defines stay in NIC-defines.v: `FLIT_WIDTH, `MAX_PACKET_LENGHT, `FLIT_TYPE_BITS, `N_BITS_FLIT_TYPE, and `HEAD_FLIT/`BODY_FLIT/`TAIL_FLIT/`HEAD_TAIL_FLIT.
- Add `PKT_LEN_WIDTH to NIC-defines.v as the default source for N_BITS_LEN.
- One sub-module: pkt_len_decoder, a combinational priority scan that outputs len and err.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with r_pkt_to_msg_i=1 → stall=0, r_msg_o=0, count_o=0; no packet stored after rst_n rises until the request is sampled.
- Single head_tail packet: push one packet with flit0 type `HEAD_TAIL_FLIT → next cycle r_msg_o=1, out_len_o=1, out_err_o=0, count_o=1; ack_msg_i=1 → count_o=0, r_msg_o=0.
- Head+2 body+tail packet (tail in flit 3), slots 4..7 holding stale tail types → out_len_o=4, out_err_o=0, and out_link_o matches in_link_i bit-exact.
- Fill: with DEPTH=4, push 4 packets without ack → stall=1, count_o=4; a 5th request plus a simultaneous ack → only the pop occurs (count_o=3); on the next cycle the 5th packet is accepted; pop order is 1..5 across the pointer wrap.
- Simultaneous push and pop at count_o=2 → count_o stays 2, head advances, and the new packet appears last.
- Malformed: flit0 type `BODY_FLIT → malformed_o pulses 1 cycle, the packet is queued with out_len_o=`MAX_PACKET_LENGHT and out_err_o=1, and the queue keeps operating normally.

Source files
------------

// File: rtl/pkt_to_msg_queue_pkg.sv
// Shared NIC flit defines and types for the receive-side packet queue.
// Everything the decoder and the queue share lives here.
`ifndef NIC_DEFINES_SV
`define NIC_DEFINES_SV
`define FLIT_WIDTH 16
`define MAX_PACKET_LENGHT 8
`define N_BITS_FLIT_TYPE 2
`define FLIT_TYPE_BITS 15:14
`define HEAD_FLIT 2'b10
`define BODY_FLIT 2'b00
`define TAIL_FLIT 2'b01
`define HEAD_TAIL_FLIT 2'b11
`define PKT_LEN_WIDTH 4
`endif

package pkt_to_msg_queue_pkg;
    localparam int FLIT_W   = `FLIT_WIDTH;
    localparam int MAX_LEN  = `MAX_PACKET_LENGHT;
    localparam int N_TYPE   = `N_BITS_FLIT_TYPE;
    localparam int TYPE_LSB = FLIT_W - N_TYPE;
    localparam int PKT_W    = MAX_LEN * FLIT_W;

    typedef logic [N_TYPE-1:0] flit_type_t;
    typedef logic [MAX_LEN-1:0][N_TYPE-1:0] type_vec_t;
endpackage

// File: rtl/pkt_to_msg_queue_pkt_len_decoder.sv
// Packet length decoder: scans flit types for the first tail.
// Head_tail is a 1-flit packet; a head without tail is malformed.
import pkt_to_msg_queue_pkg::*;

module pkt_len_decoder #(
    parameter int N_BITS_LEN = `PKT_LEN_WIDTH
) (
    input  type_vec_t             types,
    output logic [N_BITS_LEN-1:0] len,
    output logic                  err
);

    logic [N_BITS_LEN-1:0] tail_len;
    logic                  found;

    // Priority scan for the lowest tail, then classify by flit 0.
    always_comb begin
        tail_len = N_BITS_LEN'(MAX_LEN);
        found    = 1'b0;
        for (int k = MAX_LEN - 1; k >= 1; k--) begin
            if (types[k] == `TAIL_FLIT) begin
                tail_len = N_BITS_LEN'(k + 1);
                found    = 1'b1;
            end
        end
        len = N_BITS_LEN'(MAX_LEN);
        err = 1'b1;
        unique case (1'b1)
            types[0] == `HEAD_TAIL_FLIT: begin
                len = N_BITS_LEN'(1);
                err = 1'b0;
            end
            types[0] == `HEAD_FLIT: begin
                len = tail_len;
                err = ~found;
            end
            default: begin
                len = N_BITS_LEN'(MAX_LEN);
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pkt_to_msg_queue.sv
// Circular packet FIFO between the flit buffer and message assembly.
// First-word fall-through; full/empty tracked by an explicit count.
import pkt_to_msg_queue_pkg::*;

module pkt_to_msg_queue #(
    parameter int DEPTH      = 4,
    parameter int N_BITS_PTR = 2,
    parameter int N_BITS_LEN = `PKT_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r_pkt_to_msg_i,
    input  logic [PKT_W-1:0]      in_link_i,
    output logic                  stall_pkt_to_msg_o,
    output logic                  r_msg_o,
    output logic [PKT_W-1:0]      out_link_o,
    output logic [N_BITS_LEN-1:0] out_len_o,
    output logic                  out_err_o,
    input  logic                  ack_msg_i,
    output logic [N_BITS_PTR:0]   count_o,
    output logic                  malformed_o
);

    logic [PKT_W-1:0]      mem_link [DEPTH];
    logic [N_BITS_LEN-1:0] mem_len  [DEPTH];
    logic                  mem_err  [DEPTH];

    logic [N_BITS_PTR-1:0] wr_ptr;
    logic [N_BITS_PTR-1:0] rd_ptr;
    logic [N_BITS_PTR:0]   count;

    type_vec_t             types;
    logic [N_BITS_LEN-1:0] dec_len;
    logic                  dec_err;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Gather the type field of every flit for the decoder.
    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) begin
            types[k] = in_link_i[k*FLIT_W+TYPE_LSB +: N_TYPE];
        end
    end

    pkt_len_decoder #(
        .N_BITS_LEN(N_BITS_LEN)
    ) u_dec (
        .types(types),
        .len  (dec_len),
        .err  (dec_err)
    );

    assign full  = (count == (N_BITS_PTR+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = rst_n & r_pkt_to_msg_i & ~full;
    assign pop   = rst_n & ack_msg_i & ~empty;

    assign stall_pkt_to_msg_o = full;
    assign r_msg_o            = ~empty;
    assign count_o            = count;
    assign out_link_o         = mem_link[rd_ptr];
    assign out_len_o          = empty ? '0 : mem_len[rd_ptr];
    assign out_err_o          = ~empty & mem_err[rd_ptr];

    // Packet storage: written on accept, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_link[wr_ptr] <= in_link_i;
            mem_len[wr_ptr]  <= dec_len;
            mem_err[wr_ptr]  <= dec_err;
        end
    end

    // Pointers, occupancy and the malformed pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            malformed_o <= 1'b0;
        end else begin
            malformed_o <= push & dec_err;
            if (push) begin
                wr_ptr <= wr_ptr + N_BITS_PTR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + N_BITS_PTR'(1);
            end
            if (push && !pop) begin
                count <= count + (N_BITS_PTR+1)'(1);
            end else if (pop && !push) begin
                count <= count - (N_BITS_PTR+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_pkt_to_msg_queue.sv
// Directed bench for pkt_to_msg_queue with a packet scoreboard.
// Inputs change and outputs are sampled on the falling edge.
module tb_pkt_to_msg_queue;
    import pkt_to_msg_queue_pkg::*;

    localparam int W     = `MAX_PACKET_LENGHT * `FLIT_WIDTH;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] link;
        logic [3:0]   len;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r_pkt;
    logic [W-1:0] in_link;
    logic         stall;
    logic         r_msg;
    logic [W-1:0] out_link;
    logic [3:0]   out_len;
    logic         out_err;
    logic         ack_msg;
    logic [2:0]   count;
    logic         malformed;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    pkt_to_msg_queue #(
        .DEPTH(4),
        .N_BITS_PTR(2),
        .N_BITS_LEN(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .r_pkt_to_msg_i    (r_pkt),
        .in_link_i         (in_link),
        .stall_pkt_to_msg_o(stall),
        .r_msg_o           (r_msg),
        .out_link_o        (out_link),
        .out_len_o         (out_len),
        .out_err_o         (out_err),
        .ack_msg_i         (ack_msg),
        .count_o           (count),
        .malformed_o       (malformed)
    );

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // kind 0 head_tail, 1 head..tail at tk, 2 body first, 3 head no tail
    function automatic logic [W-1:0] mk(input int kind, input int tk);
        logic [W-1:0]  p;
        logic [1:0]    t;
        logic [31:0]   d;
        p = '0;
        for (int i = 0; i < `MAX_PACKET_LENGHT; i++) begin
            d = $urandom;
            t = 2'(d[31:30]);
            if (i == 0) begin
                case (kind)
                    0: t = `HEAD_TAIL_FLIT;
                    2: t = `BODY_FLIT;
                    default: t = `HEAD_FLIT;
                endcase
            end else if (kind == 1) begin
                t = (i < tk) ? `BODY_FLIT : `TAIL_FLIT;
            end else if (kind == 3) begin
                t = `BODY_FLIT;
            end
            p[i*16 +: 16] = {t, d[13:0]};
        end
        return p;
    endfunction

    task automatic step(input logic req, input logic [W-1:0] link,
                        input logic [3:0] len, input logic er,
                        input logic ack);
        bit acc;
        bit pop;
        r_pkt   = req;
        in_link = link;
        ack_msg = ack;
        acc = req && (sb.size() != DEPTH);
        pop = ack && (sb.size() != 0);
        @(posedge clk);
        @(negedge clk);
        if (pop) void'(sb.pop_front());
        if (acc) sb.push_back('{link, len, er});
        r_pkt   = 1'b0;
        ack_msg = 1'b0;
        check("count", W'(count), W'(sb.size()));
        check("stall", W'(stall), W'(sb.size() == DEPTH));
        check("r_msg", W'(r_msg), W'(sb.size() != 0));
        check("malformed", W'(malformed), W'(acc && er));
        if (sb.size() != 0) begin
            check("out_link", out_link, sb[0].link);
            check("out_len", W'(out_len), W'(sb[0].len));
            check("out_err", W'(out_err), W'(sb[0].err));
        end
    endtask

    task automatic send(input int kind, input int tk, input logic ack);
        logic [W-1:0] p;
        logic [3:0]   l;
        logic         e;
        p = mk(kind, tk);
        case (kind)
            0: begin l = 4'd1; e = 1'b0; end
            1: begin l = 4'(tk + 1); e = 1'b0; end
            default: begin l = 4'd8; e = 1'b1; end
        endcase
        step(1'b1, p, l, e, ack);
    endtask

    task automatic idle(input logic ack);
        step(1'b0, '0, 4'd0, 1'b0, ack);
    endtask

    initial begin
        rst_n   = 1'b0;
        r_pkt   = 1'b1;
        in_link = mk(0, 0);
        ack_msg = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall", W'(stall), W'(0));
        check("rst_r_msg", W'(r_msg), W'(0));
        check("rst_count", W'(count), W'(0));
        check("rst_len", W'(out_len), W'(0));
        check("rst_err", W'(out_err), W'(0));
        check("rst_malformed", W'(malformed), W'(0));
        rst_n = 1'b1;
        r_pkt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_count", W'(count), W'(0));
        check("post_rst_r_msg", W'(r_msg), W'(0));

        send(0, 0, 1'b0);
        idle(1'b1);

        send(1, 3, 1'b0);
        idle(1'b1);

        send(0, 0, 1'b0);
        send(1, 2, 1'b0);
        send(1, 7, 1'b0);
        send(1, 5, 1'b0);
        send(1, 1, 1'b1);
        check("fill_pop_only", W'(count), W'(3));
        send(1, 1, 1'b0);
        check("fill_fifth_in", W'(count), W'(4));
        repeat (4) idle(1'b1);

        send(0, 0, 1'b0);
        send(1, 4, 1'b0);
        send(1, 6, 1'b1);
        check("simul_count", W'(count), W'(2));
        repeat (2) idle(1'b1);

        send(2, 0, 1'b0);
        idle(1'b0);
        send(3, 0, 1'b0);
        send(0, 0, 1'b1);
        repeat (3) idle(1'b1);
        idle(1'b1);
        check("end_empty", W'(r_msg), W'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
